soc_system_res_ack: RTL and testbench
=====================================

Name: soc_system_res_ack

Overview:
- Fabric-to-HPS return path for the request/response handshake: fabric logic pulses or raises `done` and presents a result word.
- The block synchronises `done`, edge-detects it, latches the result and sets a sticky pending flag. It counts events, flags overruns, and raises a maskable interrupt.
- It sits on the HPS lightweight Avalon-MM bridge as a 4-word slave, next to the request output PIO.

Parameters:
DATA_WIDTH, 32, width of result_in and RESULT register (1..32; zero-extended on readdata)
SYNC_STAGES, 2, flip-flop stages on done (>=2)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
address  input  2  Avalon-MM word address
chipselect  input  1  Avalon-MM select
write_n  input  1  Avalon-MM write strobe, active-low
writedata  input  32  Avalon-MM write data
readdata  output  32  Avalon-MM read data, 0-cycle read latency
done  input  1  completion flag from fabric, asynchronous to clk
result_in  input  DATA_WIDTH  result word; stable from >=1 cycle before done rises until pending is cleared
irq  output  1  interrupt request, level, active-high

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk. All flops clear to 0: sync chain, prev-level, pending, overflow, result_reg, irq_en, count. irq=0, readdata=0 for address 0 with done=0.
- Write strobe: wr = chipselect & ~write_n. There is no read side effect.
- Sync: done passes through SYNC_STAGES flops to give done_s. Flop prev <= done_s. Event ev = done_s & ~prev (rising edge only; falling edges ignored).
- Latency: done sampled high at clk edge N gives pending=1, result latched and irq (if enabled) valid after edge N+SYNC_STAGES.
- done held high through reset release counts as one event.
- On ev:
  - result_reg <= result_in[DATA_WIDTH-1:0].
  - pending <= 1.
  - count <= count+1, 16-bit, wraps 0xFFFF->0x0000.
  - if pending already 1 and not being cleared this cycle: overflow <= 1, and result_reg takes the newest value.
- Register map (readdata combinational, unused bits read 0):
  - addr0 STATUS: R bit0 pending, bit1 overflow, bit2 done_s. W bit0=1 clears pending, bit1=1 clears overflow (write-1-to-clear); 0 bits have no effect.
  - addr1 RESULT: R result_reg zero-extended. Writes ignored.
  - addr2 IRQ_EN: R/W bit0 irq_en.
  - addr3 COUNT: R count in bits[15:0]. Any write clears count.
- Simultaneous events:
  - ev and W1C of pending in the same cycle: pending stays 1 (set wins), overflow not set.
  - ev and W1C of overflow while pending=1: overflow stays 1 (set wins).
  - ev and COUNT write in the same cycle: count=1.
- irq = pending & irq_en, registered-free combinational from flops, glitch-free. Enabling irq_en while pending=1 asserts irq the next cycle.
- The block cannot apply backpressure to the fabric; the fabric must not re-raise done before HPS clears pending, otherwise overflow is recorded.
- Reset asserted mid-operation clears all state immediately; a done pulse in flight is lost.

Test Plan:
1. Reset, then read addr0..3 -> all 0x00000000; irq=0.
2. result_in=0xCAFE_0001, irq_en=1, raise done at edge N -> after edge N+2: STATUS=0x5, RESULT=0xCAFE0001, COUNT=1, irq=1. Write addr0=0x1 -> STATUS=0x4, irq=0.
3. Two done rising edges without clearing, results 0x11 then 0x22 -> STATUS bit1=1, RESULT=0x22, COUNT=2. Write addr0=0x3 -> STATUS bits[1:0]=0.
4. W1C of pending issued on the exact cycle ev fires -> pending remains 1, overflow 0, COUNT increments.
5. Preload count to 0xFFFF via 65535 events, one more event -> COUNT=0x0000. COUNT write concurrent with ev -> COUNT=1.
6. done held high across reset release -> exactly one event (COUNT=1). A 1-cycle done glitch shorter than a clock period, sampled or not, yields at most one event.

Source files
------------

// File: rtl/soc_system_res_ack.sv
// Fabric-to-HPS completion return path: synchronises done, latches the result on each rising edge,
// keeps sticky pending/overflow flags, an event counter and a maskable level interrupt behind a 4-word Avalon-MM slave.
module soc_system_res_ack #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result_in,
  output logic                  irq
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pending;
  logic                   r_overflow;
  logic [DATA_WIDTH-1:0]  r_result;
  logic                   r_irq_en;
  logic [15:0]            r_count;

  logic w_done_s;
  logic w_ev;
  logic w_wr;
  logic w_clr_pend;
  logic w_clr_ovf;
  logic w_wr_irq_en;
  logic w_wr_count;
  logic w_unused;

  assign w_done_s    = r_sync[SYNC_STAGES-1];
  assign w_ev        = w_done_s & ~r_prev;
  assign w_wr        = chipselect & ~write_n;
  assign w_clr_pend  = w_wr && (address == 2'd0) && writedata[0];
  assign w_clr_ovf   = w_wr && (address == 2'd0) && writedata[1];
  assign w_wr_irq_en = w_wr && (address == 2'd2);
  assign w_wr_count  = w_wr && (address == 2'd3);
  assign w_unused    = ^writedata[31:2];

  // Synchroniser and edge detector: only rising edges of done_s are events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], done};
      r_prev <= w_done_s;
    end
  end

  // A new event always wins over a same-cycle W1C so no completion is silently dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
      r_result   <= '0;
    end else begin
      if (w_ev) begin
        r_pending <= 1'b1;
        r_result  <= result_in;
      end else if (w_clr_pend) begin
        r_pending <= 1'b0;
      end
      if (w_ev && r_pending && !w_clr_pend) begin
        r_overflow <= 1'b1;
      end else if (w_clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_count  <= 16'd0;
    end else begin
      if (w_wr_irq_en) begin
        r_irq_en <= writedata[0];
      end
      if (w_wr_count) begin
        r_count <= w_ev ? 16'd1 : 16'd0;
      end else if (w_ev) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[2:0] = {w_done_s, r_overflow, r_pending};
      2'd1:    readdata[DATA_WIDTH-1:0] = r_result;
      2'd2:    readdata[0] = r_irq_en;
      default: readdata[15:0] = r_count;
    endcase
  end

  assign irq = r_pending & r_irq_en;

endmodule

// File: tb/tb_soc_system_res_ack.sv
// Directed bench for soc_system_res_ack: vector table for the register map and handshake,
// hand-written sequences for same-cycle collisions, counter wrap, reset and glitches on done.
module tb_soc_system_res_ack;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        done = 1'b0;
  logic [31:0] result_in = '0;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  soc_system_res_ack #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .done       (done),
    .result_in  (result_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic [31:0] result;
    logic        wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    int          ncyc;
    logic [1:0]  raddr;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic d, logic [31:0] res, logic w, logic [1:0] wa, logic [31:0] wd,
                              int n, logic [1:0] ra, logic [31:0] e, logic ei);
    vec_t v;
    v.done = d; v.result = res; v.wr = w; v.waddr = wa; v.wdata = wd;
    v.ncyc = n; v.raddr = ra; v.exp = e; v.exp_irq = ei;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk(nm, readdata, exp);
    chipselect = 1'b0;
  endtask

  // One full done pulse: ev fires on the third edge, done_s back low two edges after release.
  task automatic pulse(input logic [31:0] res);
    result_in = res; done = 1'b1;
    tick(3);
    done = 1'b0;
    tick(2);
  endtask

  initial begin
    // Reset / map / basic handshake / overflow / W1C-zero / write-ignored / irq masking.
    vecs.push_back(mk(0, 32'h0,          0, 2'd0, 32'h0,        0, 2'd0, 32'h0,          0));
    vecs.push_back(mk(0, 32'h0,          0, 2'd0, 32'h0,        0, 2'd1, 32'h0,          0));
    vecs.push_back(mk(0, 32'h0,          0, 2'd0, 32'h0,        0, 2'd2, 32'h0,          0));
    vecs.push_back(mk(0, 32'h0,          0, 2'd0, 32'h0,        0, 2'd3, 32'h0,          0));
    vecs.push_back(mk(0, 32'h0,          1, 2'd2, 32'h1,        0, 2'd2, 32'h1,          0));
    vecs.push_back(mk(1, 32'hCAFE_0001,  0, 2'd0, 32'h0,        3, 2'd0, 32'h5,          1));
    vecs.push_back(mk(1, 32'hCAFE_0001,  0, 2'd0, 32'h0,        0, 2'd1, 32'hCAFE_0001,  1));
    vecs.push_back(mk(1, 32'hCAFE_0001,  0, 2'd0, 32'h0,        0, 2'd3, 32'h1,          1));
    vecs.push_back(mk(1, 32'hCAFE_0001,  1, 2'd0, 32'h1,        0, 2'd0, 32'h4,          0));
    vecs.push_back(mk(0, 32'hCAFE_0001,  0, 2'd0, 32'h0,        3, 2'd0, 32'h0,          0));
    vecs.push_back(mk(0, 32'h0,          1, 2'd3, 32'h0,        0, 2'd3, 32'h0,          0));
    vecs.push_back(mk(1, 32'h11,         0, 2'd0, 32'h0,        3, 2'd0, 32'h5,          1));
    vecs.push_back(mk(0, 32'h11,         0, 2'd0, 32'h0,        3, 2'd0, 32'h1,          1));
    vecs.push_back(mk(1, 32'h22,         0, 2'd0, 32'h0,        3, 2'd0, 32'h7,          1));
    vecs.push_back(mk(1, 32'h22,         0, 2'd0, 32'h0,        0, 2'd1, 32'h22,         1));
    vecs.push_back(mk(1, 32'h22,         0, 2'd0, 32'h0,        0, 2'd3, 32'h2,          1));
    vecs.push_back(mk(0, 32'h22,         1, 2'd0, 32'h3,        2, 2'd0, 32'h0,          0));
    vecs.push_back(mk(1, 32'h33,         0, 2'd0, 32'h0,        3, 2'd0, 32'h5,          1));
    vecs.push_back(mk(1, 32'h33,         1, 2'd0, 32'h0,        0, 2'd0, 32'h5,          1));
    vecs.push_back(mk(1, 32'h33,         1, 2'd1, 32'hFFFF_FFFF,0, 2'd1, 32'h33,         1));
    vecs.push_back(mk(1, 32'h33,         1, 2'd2, 32'h0,        0, 2'd2, 32'h0,          0));
    vecs.push_back(mk(1, 32'h33,         1, 2'd2, 32'h1,        0, 2'd0, 32'h5,          1));
    vecs.push_back(mk(0, 32'h33,         1, 2'd0, 32'h1,        2, 2'd0, 32'h0,          0));

    tick(2);
    reset_n = 1'b1;
    tick(1);

    foreach (vecs[i]) begin
      done = vecs[i].done;
      result_in = vecs[i].result;
      if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata);
      tick(vecs[i].ncyc);
      chk_rd($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // W1C of pending on the exact ev cycle: set wins, no overflow, count still increments.
    wr(2'd3, 32'h0);
    pulse(32'h44);
    result_in = 32'h55; done = 1'b1;
    tick(2);
    wr(2'd0, 32'h1);
    chk_rd("w1c_vs_ev_status", 2'd0, 32'h5);
    chk_rd("w1c_vs_ev_result", 2'd1, 32'h55);
    chk_rd("w1c_vs_ev_count", 2'd3, 32'h2);
    done = 1'b0;
    tick(2);

    // W1C of overflow on the ev cycle while pending: overflow stays set.
    wr(2'd0, 32'h3);
    pulse(32'h66);
    pulse(32'h77);
    chk_rd("ovf_pre", 2'd0, 32'h3);
    result_in = 32'h88; done = 1'b1;
    tick(2);
    wr(2'd0, 32'h2);
    chk_rd("w1c_ovf_vs_ev", 2'd0, 32'h7);
    done = 1'b0;
    tick(2);
    wr(2'd0, 32'h3);

    // Counter wrap, starting just below the top to stay within a short run.
    force dut.r_count = 16'hFFFE;
    tick(1);
    release dut.r_count;
    chk_rd("count_preload", 2'd3, 32'h0000_FFFE);
    pulse(32'h1);
    chk_rd("count_ffff", 2'd3, 32'h0000_FFFF);
    pulse(32'h2);
    chk_rd("count_wrap", 2'd3, 32'h0);
    pulse(32'h3);
    pulse(32'h4);
    chk_rd("count_two", 2'd3, 32'h2);
    result_in = 32'h5; done = 1'b1;
    tick(2);
    wr(2'd3, 32'h0);
    chk_rd("count_wr_vs_ev", 2'd3, 32'h1);
    done = 1'b0;
    tick(2);

    // Reset mid-operation with pending and irq active.
    chk("irq_before_rst", {31'd0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("irq_in_rst", {31'd0, irq}, 32'h0);
    chk_rd("status_in_rst", 2'd0, 32'h0);
    chk_rd("count_in_rst", 2'd3, 32'h0);

    // done high across reset release: exactly one event.
    done = 1'b1; result_in = 32'h99;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    chk_rd("rst_done_count", 2'd3, 32'h1);
    chk_rd("rst_done_status", 2'd0, 32'h5);
    chk_rd("rst_done_irqen", 2'd2, 32'h0);
    done = 1'b0;
    tick(3);
    wr(2'd0, 32'h3);
    wr(2'd3, 32'h0);

    // Glitch between clock edges: never sampled, no event.
    done = 1'b1;
    #2 done = 1'b0;
    tick(5);
    chk_rd("glitch_unsampled", 2'd3, 32'h0);
    // Glitch straddling a rising edge: sampled once, one event.
    #3 done = 1'b1;
    #3 done = 1'b0;
    tick(5);
    chk_rd("glitch_sampled", 2'd3, 32'h1);
    chk_rd("glitch_status", 2'd0, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
